ram_sized_ctrl: RTL
===================

Name: ram_sized_ctrl

Overview:
- Clocked, parametrised byte-addressable RAM with a registered mv/moc handshake.
- Supports byte, halfword, word and doubleword accesses, stored big-endian.
- Adds configurable access latency, alignment/range error reporting and optional sign-extension on reads.
- Sits between the CPU memory-access stage and the data store; it replaces the unclocked fixed 256-byte memory.

Parameters:
- ADDR_W, 8, byte-address width; depth = 2**ADDR_W bytes.
- LATENCY, 2, wait cycles spent in BUSY before the access completes (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mv  in  1  memory-valid request; held high until moc is seen.
- rw  in  1  1 = read, 0 = write.
- type_data  in  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- sign_ext  in  1  on reads, sign-extend the result to 64 bits; otherwise zero-extend.
- address  in  ADDR_W  byte address of the most-significant byte.
- data_in  in  64  write data, right-justified (byte uses [7:0], halfword [15:0], ...).
- data_out  out  64  read data, right-justified, extended per sign_ext.
- moc  out  1  memory-operation-complete.
- err  out  1  valid with moc; 1 = access rejected.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state = IDLE, moc = 0, err = 0, data_out = 0. Memory contents are not reset.
- IDLE state:
  - On a clk edge with mv = 1, latch rw, type_data, sign_ext, address and data_in.
  - Then go to BUSY (LATENCY > 0) or ACCESS (LATENCY = 0).
- BUSY state: counts LATENCY cycles, then goes to ACCESS. Inputs are ignored while BUSY.
- ACCESS state (single cycle):
  - Compute size n = 1, 2, 4 or 8 bytes.
  - Misaligned when address mod n != 0. Out of range when address + n - 1 > 2**ADDR_W - 1, using ADDR_W+1-bit arithmetic with no wrap.
  - Error case: no memory access; err = 1; data_out is unchanged.
  - Write: mem[a+i] = data_in[8(n-i)-1 -: 8] for i = 0..n-1. Bytes outside the access are unchanged.
  - Read: data_out = {mem[a], ..., mem[a+n-1]} in the low 8n bits. Upper bits are all 0, or copies of bit 8n-1 when sign_ext = 1. Doubleword reads ignore sign_ext.
  - Set moc = 1, then go to DONE.
- Latency: moc rises at the edge T0 + LATENCY + 1, where T0 is the edge that sampled mv in IDLE.
- DONE state:
  - moc, err and data_out hold while mv = 1.
  - On the first edge with mv = 0: moc = 0, err = 0, go to IDLE. data_out keeps its value.
  - A new request needs mv low for at least one edge. mv still high in DONE never starts a second access.
- Simultaneous reset and any event: reset wins.
- Reset in BUSY or in the ACCESS edge: the pending write is not performed.
- Only one request is outstanding at a time; there is no queueing.

Decomposition:
- Package ram_sized_pkg:
  - Type constants TD_BYTE = 2'b00, TD_HALF = 2'b01, TD_WORD = 2'b10, TD_DWORD = 2'b11.
  - State encoding IDLE, BUSY, ACCESS, DONE.
  - Function returning the size in bytes from type_data.
- Sub-module ram_byte_array:
  - Storage of 2**ADDR_W x 8 bits.
  - 8 byte-lane read ports and 8 write-enabled byte-lane write ports at address + lane.
  - Synchronous write, combinational read.
- Top level: FSM, latency counter, error check, lane steering and extension.

Test Plan:
- Doubleword round trip: write dword 0x0123456789ABCDEF at 0x10, then read a byte at 0x10 -> data_out = 0x01. Read half at 0x16 -> 0xCDEF. Read dword at 0x10 -> original value. Each moc arrives exactly LATENCY+1 edges after mv is sampled.
- Sign extension: write byte 0x80 at 0x20 and half 0x7FFF at 0x22. Read byte at 0x20 with sign_ext = 1 -> 0xFFFFFFFFFFFFFF80, with sign_ext = 0 -> 0x80. Read half at 0x22 with sign_ext = 1 -> 0x7FFF.
- Errors:
  - Word write at 0x13 -> err = 1, moc = 1; memory at 0x13..0x16 is unchanged.
  - Dword read at 0xF8 (ADDR_W = 8) -> err = 0.
  - Half access at 0xFF -> err = 1, because it is misaligned.
- Handshake: hold mv high 5 cycles past moc -> moc stays 1 and exactly one access occurs. Drop mv -> moc = 0 on the next edge. Re-raise mv -> a new access starts.
- Reset mid-operation: assert reset in BUSY during a dword write of 0xFF..FF to 0x00 -> moc = 0, state IDLE, and a following read of 0x00 returns the prior contents.
- LATENCY = 0 build: a byte read gives moc one edge after mv is sampled, with correct data.

Source files
------------

// File: rtl/ram_sized_pkg.sv
// ---------------------------------------------------------------------------
// ram_sized_pkg
// Shared constants for the sized RAM controller:
//   - access-size codes carried on type_data
//   - controller state encoding
//   - size_bytes(): number of bytes touched by an access of a given type
// ---------------------------------------------------------------------------
package ram_sized_pkg;

    // type_data codes
    localparam logic [1:0] TD_BYTE  = 2'b00;
    localparam logic [1:0] TD_HALF  = 2'b01;
    localparam logic [1:0] TD_WORD  = 2'b10;
    localparam logic [1:0] TD_DWORD = 2'b11;

    // controller states
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // 1, 2, 4 or 8 bytes
    function automatic logic [3:0] size_bytes(input logic [1:0] td);
        return 4'd1 << td;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// ---------------------------------------------------------------------------
// ram_byte_array
// Byte-wide storage of 2**ADDR_W bytes with eight byte lanes. Lane i reads
// and writes the byte at addr + i. Lane data is packed most-significant lane
// first: lane 0 occupies [63:56], lane 7 occupies [7:0].
// Ports:
//   clk    in   system clock, rising edge (writes)
//   addr   in   base byte address for lane 0
//   we     in   per-lane write enable (bit i = lane i)
//   wdata  in   lane write data
//   rdata  out  lane read data, combinational
// ---------------------------------------------------------------------------
module ram_byte_array
    import ram_sized_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        we,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] lane_addr [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            // Lanes past the end wrap; the controller never enables a write
            // on such a lane, and wrapped read lanes are discarded upstream.
            assign lane_addr[gi]           = addr + ADDR_W'(gi);
            assign rdata[63-8*gi -: 8]     = mem[lane_addr[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we[i]) begin
                mem[lane_addr[i]] <= wdata[63-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/ram_sized_ctrl.sv
// ---------------------------------------------------------------------------
// ram_sized_ctrl
// Byte-addressable big-endian RAM behind a registered mv/moc handshake.
// A request is latched in IDLE, waits LATENCY cycles in BUSY, performs the
// access in ACCESS and then holds its result in DONE until mv drops.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   mv         in   request valid, held until moc
//   rw         in   1 = read, 0 = write
//   type_data  in   access size: byte / half / word / dword
//   sign_ext   in   sign-extend read data (ignored for dword)
//   address    in   byte address of the most-significant byte
//   data_in    in   right-justified write data
//   data_out   out  right-justified read data
//   moc        out  operation complete
//   err        out  access rejected (misaligned or out of range), valid with moc
// ---------------------------------------------------------------------------
module ram_sized_ctrl
    import ram_sized_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mv,
    input  logic              rw,
    input  logic [1:0]        type_data,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       data_in,
    output logic [63:0]       data_out,
    output logic              moc,
    output logic              err
);

    localparam int         DEPTH  = 1 << ADDR_W;
    // Range arithmetic is one bit wider than the address so the end address
    // never wraps; at least 4 bits so size-1 always fits.
    localparam int         EW     = (ADDR_W + 1 > 4) ? ADDR_W + 1 : 4;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]        state_reg;
    logic [3:0]        cnt_reg;
    logic              rw_reg;
    logic [1:0]        td_reg;
    logic              sx_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [63:0]       din_reg;

    logic [3:0]        size;
    logic [3:0]        size_m1;
    logic [6:0]        shift_bits;
    logic [EW-1:0]     addr_ext;
    logic [EW-1:0]     end_addr;
    logic              misaligned;
    logic              out_of_range;
    logic              access_err;
    logic              do_write;
    logic [7:0]        lane_we;
    logic [63:0]       wr_aligned;
    logic [63:0]       rd_left;
    logic [63:0]       rd_raw;
    logic [63:0]       ext_mask;
    logic [63:0]       rd_data;

    // ------------------------------------------------------------------
    // Error check on the latched request
    // ------------------------------------------------------------------
    assign size         = size_bytes(td_reg);
    assign size_m1      = size - 4'd1;
    assign addr_ext     = EW'(addr_reg);
    assign end_addr     = addr_ext + EW'(size_m1);
    assign misaligned   = (addr_ext & EW'(size_m1)) != '0;
    assign out_of_range = end_addr > EW'(DEPTH - 1);
    assign access_err   = misaligned | out_of_range;

    // ------------------------------------------------------------------
    // Lane steering. Data is moved to a left-justified form so that the
    // access's most-significant byte always sits on lane 0 (address a).
    // shift_bits = 8 * (8 - n).
    // ------------------------------------------------------------------
    assign shift_bits = {4'd8 - size, 3'b000};
    assign wr_aligned = din_reg << shift_bits;

    // A reset coinciding with the ACCESS edge must suppress the write.
    assign do_write = (state_reg == ACCESS) && !access_err && !rw_reg && !reset;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_we
            assign lane_we[gi] = do_write && (4'(gi) < size);
        end
    endgenerate

    ram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .addr  (addr_reg),
        .we    (lane_we),
        .wdata (wr_aligned),
        .rdata (rd_left)
    );

    // Read: right-justify, then fill the upper bits with the access's MSB
    // when sign-extending. For a dword the mask is empty, so sign_ext has
    // no effect there.
    assign rd_raw   = rd_left >> shift_bits;
    assign ext_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> shift_bits);
    assign rd_data  = (sx_reg && rd_left[63]) ? (rd_raw | ext_mask) : rd_raw;

    // ------------------------------------------------------------------
    // Request latch (no reset needed; only meaningful after IDLE accepts)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && mv && !reset) begin
            rw_reg   <= rw;
            td_reg   <= type_data;
            sx_reg   <= sign_ext;
            addr_reg <= address;
            din_reg  <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            moc       <= 1'b0;
            err       <= 1'b0;
            data_out  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mv) begin
                        if (LATENCY > 0) begin
                            state_reg <= BUSY;
                            cnt_reg   <= LAT_M1;
                        end else begin
                            state_reg <= ACCESS;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= ACCESS;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ACCESS: begin
                    moc <= 1'b1;
                    err <= access_err;
                    if (!access_err && rw_reg) begin
                        data_out <= rd_data;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    // Hold everything until the requester drops mv.
                    if (!mv) begin
                        moc       <= 1'b0;
                        err       <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
